// File: rtl/typewriter_out_pkg.sv
// Shared G-15 typewriter code points, ASCII constants, emitter states and
// the code-to-ASCII translation used by typewriter_out.
package g15_tw_pkg;

  localparam logic [4:0] TW_SPACE  = 5'h00;
  localparam logic [4:0] TW_MINUS  = 5'h01;
  localparam logic [4:0] TW_CR     = 5'h02;
  localparam logic [4:0] TW_TAB    = 5'h03;
  localparam logic [4:0] TW_STOP   = 5'h04;
  localparam logic [4:0] TW_RELOAD = 5'h05;
  localparam logic [4:0] TW_PERIOD = 5'h06;
  localparam logic [4:0] TW_WAIT   = 5'h07;

  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam logic [7:0] ASCII_MINUS  = 8'h2D;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_TAB    = 8'h09;
  localparam logic [7:0] ASCII_PERIOD = 8'h2E;
  localparam logic [7:0] ASCII_QMARK  = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_SEND_LF
  } tw_state_e;

  // 0x10-0x19 are the decimal digits; 0x1A-0x1F are the hex digits u..z.
  function automatic logic [7:0] tw_to_ascii(input logic [4:0] code);
    logic [7:0] a;
    a = ASCII_QMARK;
    case (code)
      TW_SPACE:  a = ASCII_SPACE;
      TW_MINUS:  a = ASCII_MINUS;
      TW_CR:     a = ASCII_CR;
      TW_TAB:    a = ASCII_TAB;
      TW_PERIOD: a = ASCII_PERIOD;
      default: begin
        if (code >= 5'h1A)
          a = 8'h5B + {3'b000, code};
        else if (code[4])
          a = {4'h3, code[3:0]};
      end
    endcase
    return a;
  endfunction

endpackage

// File: rtl/typewriter_out_if.sv
// Byte stream from the typewriter emitter to the host serial link.
interface typewriter_out_if;
  import g15_tw_pkg::*;

  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;

  modport master (output TX_DATA, output TX_VALID, input TX_READY);
  modport slave  (input TX_DATA, input TX_VALID, output TX_READY);

endinterface

// File: rtl/typewriter_out_fifo.sv
// Small power-of-two FIFO of 5-bit typewriter codes; a push into a full FIFO
// is still accepted when a pop happens in the same cycle.
module tw_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [4:0]               wr_data,
  output logic [4:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = push & (~full | pop);
  assign rd_en   = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/typewriter_out.sv
// Captures G-15 typewriter characters from io_top, queues them and streams
// their ASCII translation to the host over a valid/ready link.
module typewriter_out
  import g15_tw_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter bit CRLF      = 1'b1,
  parameter bit DROP_CTRL = 1'b1
) (
  input  logic CLOCK,
  input  logic rst,
  input  logic TYPE,
  input  logic TYPE_PULSE,
  input  logic OB1,
  input  logic OB2,
  input  logic OB3,
  input  logic OB4,
  input  logic OB5,
  typewriter_out_if.master tx,
  output logic BUSY,
  output logic OVERFLOW,
  input  logic OVF_CLR
);

  logic                   pulse_q;
  logic [4:0]             code;
  logic                   is_ctrl;
  logic                   push;
  logic                   pop;
  logic [4:0]             head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   ovf_set;

  tw_state_e  state, state_nxt;
  logic [7:0] tx_data_p0, tx_data_nxt;
  logic       tx_valid_p0, tx_valid_nxt;
  logic       fire;

  assign code    = {OB5, OB4, OB3, OB2, OB1};
  assign is_ctrl = (code == TW_STOP) | (code == TW_RELOAD) | (code == TW_WAIT);
  // Rising edge of the strobe only; TYPE must already be up at that edge.
  assign push    = TYPE & TYPE_PULSE & ~pulse_q & ~(DROP_CTRL & is_ctrl);
  assign ovf_set = push & fifo_full & ~pop;

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      pulse_q  <= 1'b0;
      OVERFLOW <= 1'b0;
    end else begin
      pulse_q <= TYPE_PULSE;
      if (ovf_set)      OVERFLOW <= 1'b1;
      else if (OVF_CLR) OVERFLOW <= 1'b0;
    end
  end

  tw_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (CLOCK),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (code),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign fire = tx_valid_p0 & tx.TX_READY;

  always_ff @(posedge CLOCK or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      tx_valid_p0 <= 1'b0;
      tx_data_p0  <= 8'h00;
    end else begin
      state       <= state_nxt;
      tx_valid_p0 <= tx_valid_nxt;
      tx_data_p0  <= tx_data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (!fifo_empty) state_nxt = ST_SEND;
      ST_SEND:
        if (fire) begin
          if (CRLF && tx_data_p0 == ASCII_CR) state_nxt = ST_SEND_LF;
          else if (fifo_empty)                state_nxt = ST_IDLE;
          else                                state_nxt = ST_SEND;
        end
      ST_SEND_LF:
        if (fire) state_nxt = fifo_empty ? ST_IDLE : ST_SEND;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Only CR translates to 0x0D, so the held byte identifies a pending LF.
  always_comb begin
    pop          = 1'b0;
    tx_valid_nxt = tx_valid_p0;
    tx_data_nxt  = tx_data_p0;
    case (state)
      ST_IDLE:
        if (!fifo_empty) begin
          pop          = 1'b1;
          tx_valid_nxt = 1'b1;
          tx_data_nxt  = tw_to_ascii(head);
        end
      ST_SEND, ST_SEND_LF:
        if (fire) begin
          if (state == ST_SEND && CRLF && tx_data_p0 == ASCII_CR) begin
            tx_data_nxt = ASCII_LF;
          end else if (!fifo_empty) begin
            pop         = 1'b1;
            tx_data_nxt = tw_to_ascii(head);
          end else begin
            tx_valid_nxt = 1'b0;
          end
        end
      default: tx_valid_nxt = 1'b0;
    endcase
  end

  assign tx.TX_DATA  = tx_data_p0;
  assign tx.TX_VALID = tx_valid_p0;
  assign BUSY        = (fifo_count != '0) | tx_valid_p0;

endmodule

// File: tb/tb_typewriter_out.sv
// Directed bench for typewriter_out: capture, translation, CR/LF, filtering,
// overflow, full-FIFO pass-through and asynchronous reset.
module tb_typewriter_out;

  logic       CLOCK = 1'b0;
  logic       rst = 1'b0;
  logic       TYPE = 1'b0;
  logic       TYPE_PULSE = 1'b0;
  logic [4:0] ob = 5'h00;
  logic       BUSY;
  logic       OVERFLOW;
  logic       OVF_CLR = 1'b0;

  int total = 0;
  int bad = 0;
  logic [7:0] q[$];

  typewriter_out_if tx_if ();

  typewriter_out dut (
    .CLOCK      (CLOCK),
    .rst        (rst),
    .TYPE       (TYPE),
    .TYPE_PULSE (TYPE_PULSE),
    .OB1        (ob[0]),
    .OB2        (ob[1]),
    .OB3        (ob[2]),
    .OB4        (ob[3]),
    .OB5        (ob[4]),
    .tx         (tx_if),
    .BUSY       (BUSY),
    .OVERFLOW   (OVERFLOW),
    .OVF_CLR    (OVF_CLR)
  );

  always #5 CLOCK = ~CLOCK;

  // Bytes accepted by the host: inputs are settled by the falling edge.
  always @(negedge CLOCK) begin
    if (rst && tx_if.TX_VALID && tx_if.TX_READY) q.push_back(tx_if.TX_DATA);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic strobe(input logic [4:0] code);
    ob = code;
    TYPE_PULSE = 1'b1;
    cyc();
    TYPE_PULSE = 1'b0;
    cyc();
  endtask

  function automatic logic [7:0] qat(input int i);
    return (i < q.size()) ? q[i] : 8'hFF;
  endfunction

  initial begin
    tx_if.TX_READY = 1'b0;
    repeat (3) cyc();
    chk("rst_valid", tx_if.TX_VALID, 0);
    chk("rst_data", tx_if.TX_DATA, 8'h00);
    chk("rst_busy", BUSY, 0);
    chk("rst_ovf", OVERFLOW, 0);
    rst = 1'b1;
    cyc();

    // Strobe while TYPE is low, then TYPE rising under the held strobe.
    ob = 5'h12;
    TYPE_PULSE = 1'b1;
    cyc();
    TYPE = 1'b1;
    repeat (2) cyc();
    TYPE_PULSE = 1'b0;
    cyc();
    chk("type_gate_busy", BUSY, 0);

    // Single digit with a 3-cycle strobe.
    q.delete();
    tx_if.TX_READY = 1'b1;
    ob = 5'h15;
    TYPE_PULSE = 1'b1;
    cyc();
    chk("t1_busy", BUSY, 1);
    chk("t1_valid_early", tx_if.TX_VALID, 0);
    cyc();
    chk("t1_valid", tx_if.TX_VALID, 1);
    chk("t1_data", tx_if.TX_DATA, 8'h35);
    cyc();
    TYPE_PULSE = 1'b0;
    repeat (4) cyc();
    chk("t1_count", q.size(), 1);
    chk("t1_byte", qat(0), 8'h35);
    chk("t1_idle", BUSY, 0);

    // CR expansion with a stalled host.
    q.delete();
    tx_if.TX_READY = 1'b0;
    ob = 5'h02;
    TYPE_PULSE = 1'b1;
    cyc();
    TYPE_PULSE = 1'b0;
    cyc();
    ob = 5'h1A;
    TYPE_PULSE = 1'b1;
    cyc();
    TYPE_PULSE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_data", tx_if.TX_DATA, 8'h0D);
      chk("t2_hold_valid", tx_if.TX_VALID, 1);
      cyc();
    end
    tx_if.TX_READY = 1'b1;
    repeat (6) cyc();
    chk("t2_count", q.size(), 3);
    chk("t2_b0", qat(0), 8'h0D);
    chk("t2_b1", qat(1), 8'h0A);
    chk("t2_b2", qat(2), 8'h75);
    chk("t2_idle", BUSY, 0);

    // Control codes dropped, unknown code becomes '?'.
    q.delete();
    strobe(5'h04);
    strobe(5'h07);
    strobe(5'h0B);
    repeat (5) cyc();
    chk("t3_count", q.size(), 1);
    chk("t3_byte", qat(0), 8'h3F);
    chk("t3_ovf", OVERFLOW, 0);

    // Overflow: ten digits into a stalled path of one register + 8 slots.
    q.delete();
    tx_if.TX_READY = 1'b0;
    for (int i = 0; i < 10; i++) strobe(5'h10 + 5'(i));
    chk("t4_ovf_set", OVERFLOW, 1);
    chk("t4_head", tx_if.TX_DATA, 8'h30);
    chk("t4_busy", BUSY, 1);
    tx_if.TX_READY = 1'b1;
    repeat (12) cyc();
    chk("t4_count", q.size(), 9);
    for (int i = 0; i < 9; i++) chk("t4_byte", qat(i), 8'h30 + 8'(i));
    chk("t4_ovf_sticky", OVERFLOW, 1);
    OVF_CLR = 1'b1;
    cyc();
    OVF_CLR = 1'b0;
    chk("t4_ovf_clr", OVERFLOW, 0);

    // Full FIFO: pop and push on the same edge.
    q.delete();
    tx_if.TX_READY = 1'b0;
    for (int i = 0; i < 9; i++) strobe(5'h10 + 5'(i));
    chk("t5_full", dut.u_fifo.count, 8);
    ob = 5'h19;
    TYPE_PULSE = 1'b1;
    tx_if.TX_READY = 1'b1;
    cyc();
    TYPE_PULSE = 1'b0;
    chk("t5_count_kept", dut.u_fifo.count, 8);
    chk("t5_ovf", OVERFLOW, 0);
    chk("t5_next", tx_if.TX_DATA, 8'h31);
    repeat (12) cyc();
    chk("t5_total", q.size(), 10);
    chk("t5_last", qat(9), 8'h39);

    // Asynchronous reset while holding the LF of a CR with 3 codes queued.
    tx_if.TX_READY = 1'b0;
    strobe(5'h02);
    strobe(5'h11);
    strobe(5'h12);
    strobe(5'h13);
    tx_if.TX_READY = 1'b1;
    cyc();
    tx_if.TX_READY = 1'b0;
    chk("t6_lf", tx_if.TX_DATA, 8'h0A);
    chk("t6_queued", dut.u_fifo.count, 3);
    q.delete();
    rst = 1'b0;
    #1;
    chk("t6_async_valid", tx_if.TX_VALID, 0);
    chk("t6_async_busy", BUSY, 0);
    repeat (2) cyc();
    chk("t6_data", tx_if.TX_DATA, 8'h00);
    rst = 1'b1;
    tx_if.TX_READY = 1'b1;
    repeat (6) cyc();
    chk("t6_no_bytes", q.size(), 0);
    chk("t6_idle", BUSY, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/typewriter_out.md
Name: typewriter_out

Overview:
- Downstream consumer of io_top's typewriter output path.
- Captures each 5-bit G-15 typewriter character presented on OB5..OB1 when TYPE_PULSE strobes while TYPE is asserted.
- Buffers captured codes in a small FIFO, translates them to ASCII (CR expands to CR LF), and streams the bytes to a host serial link over a valid/ready handshake.
- Replaces the physical Flexowriter print mechanism in the FPGA build.

Parameters:
- DEPTH, 8, FIFO depth in 5-bit codes; power of two, minimum 2.
- CRLF, 1, 1 = CR code emits 0x0D then 0x0A; 0 = emits 0x0D only.
- DROP_CTRL, 1, 1 = stop/reload/wait codes are discarded at capture; 0 = they are enqueued and emitted as '?'.

Ports:
- CLOCK  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- TYPE  in  1  typewriter selected as output device (io_top).
- TYPE_PULSE  in  1  character strobe (io_top); may be high for several cycles.
- OB1, OB2, OB3, OB4, OB5  in  1 each  output character bits (io_top); OB5 = MSB, OB1 = LSB.
- TX_DATA  out  8  ASCII byte to host.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  host accepts byte.
- BUSY  out  1  FIFO non-empty or a byte is pending or emitting.
- OVERFLOW  out  1  sticky flag: a character was lost because the FIFO was full.
- OVF_CLR  in  1  synchronous clear of OVERFLOW.

Behaviour:
- Reset (rst = 0, asynchronous):
  - FIFO empty; state IDLE; TX_VALID = 0; TX_DATA = 0x00; BUSY = 0; OVERFLOW = 0.
  - Edge-detect register = 0.
  - Reset mid-emission discards all queued and pending characters.
- Capture:
  - Register pulse_q <= TYPE_PULSE.
  - push = TYPE & TYPE_PULSE & ~pulse_q. Exactly one capture per strobe regardless of width.
  - The code {OB5..OB1} is sampled in the same cycle as push.
  - TYPE_PULSE high with TYPE = 0 is ignored, and a later rise of TYPE while the strobe is still high does not capture.
- Control-code filtering: with DROP_CTRL = 1, codes 0x04, 0x05 and 0x07 are not enqueued and do not affect OVERFLOW.
- FIFO:
  - Count width is clog2(DEPTH)+1; pointers wrap modulo DEPTH.
  - A push is accepted when count < DEPTH, or when a pop occurs in the same cycle (so full + push + pop keeps the count at DEPTH).
  - A rejected push sets OVERFLOW.
  - OVF_CLR clears OVERFLOW. If a rejected push and OVF_CLR occur in the same cycle, the set wins.
- Translation:
  - 0x00 → ' ' (0x20)
  - 0x01 → '-' (0x2D)
  - 0x02 → CR (0x0D)
  - 0x03 → TAB (0x09)
  - 0x06 → '.' (0x2E)
  - 0x10–0x19 → '0'–'9' (0x30–0x39)
  - 0x1A–0x1F → 'u','v','w','x','y','z' (0x75–0x7A)
  - All other codes → '?' (0x3F)
- Emitter FSM:
  - IDLE: if FIFO non-empty, pop the head, load TX_DATA with its translation, set TX_VALID, go to SEND.
  - SEND: hold TX_DATA and TX_VALID stable until TX_READY. On TX_VALID & TX_READY:
    - head was CR and CRLF = 1 → load 0x0A, go to SEND_LF;
    - else if FIFO non-empty → pop the next code and load it (back-to-back, no bubble);
    - else clear TX_VALID and go to IDLE.
  - SEND_LF: hold 0x0A until TX_READY, then apply the same next-code/IDLE rule as SEND.
- Latency and throughput:
  - A capture edge at cycle n makes the FIFO non-empty after edge n.
  - TX_VALID rises after edge n+1 when the FIFO was empty and the FSM was IDLE.
  - Sustained throughput is one byte per cycle with TX_READY held at 1.
- BUSY = (count != 0) | TX_VALID.

Decomposition:
- Package g15_tw_pkg holds:
  - localparams for the special codes (TW_SPACE, TW_MINUS, TW_CR, TW_TAB, TW_STOP, TW_RELOAD, TW_PERIOD, TW_WAIT);
  - ASCII constants;
  - the emitter state enum;
  - function tw_to_ascii(logic [4:0]) returning logic [7:0].
- One sub-module, tw_fifo (parameter DEPTH; push/pop/full/empty/count ports), instantiated once.
- Capture, filtering and the FSM stay in typewriter_out.

Test Plan:
- Single digit: TYPE = 1, OB = 0x15, TYPE_PULSE high for 3 cycles, TX_READY = 1 → exactly one byte 0x35; TX_VALID rises 2 cycles after the rising edge; BUSY returns to 0.
- CR expansion: enqueue 0x02 then 0x1A with TX_READY stalled 4 cycles → bytes 0x0D, 0x0A, 0x75 in order; TX_DATA stable during the stall.
- Filtering: codes 0x04, 0x07, 0x0B with DROP_CTRL = 1 → one byte 0x3F only; OVERFLOW stays 0.
- Overflow: TX_READY = 0, DEPTH = 8, push 10 distinct digits → OVERFLOW = 1. With TX_READY then 1, the output is exactly 9 bytes: the first digit (popped into TX_DATA), then the next 8 queued digits. Digit 10 is lost. OVF_CLR then clears the flag.
- Full + simultaneous pop/push: FIFO full, TX_READY = 1 in the same cycle as a new capture → capture accepted, count stays 8, OVERFLOW = 0.
- Reset mid-stream: assert rst low while in SEND_LF with 3 codes queued → TX_VALID = 0 and BUSY = 0 immediately (asynchronous); no bytes are emitted after release.
